cam_bin_sampler: RTL and testbench



---
 rtl/cam_bin_sampler.sv | 190 +++++++++++++++++++
 tb/tb_cam_bin_sampler.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/cam_bin_sampler.sv
// cam_bin_sampler
//   Downscales the raw OV2640 pixel stream into an IMG_W x IMG_H binary image
//   for the LUT-network classifier. Each output cell covers a
//   2^SHIFT_X x 2^SHIFT_Y pixel block starting at (OFFSET_X, OFFSET_Y). The
//   cell value is either the top-left pixel of the block (point mode) or the
//   block mean (average mode), compared against a threshold and optionally
//   inverted. The image is built in a work buffer and copied to out_img only
//   when a frame has delivered every ROI line.
//
// Ports
//   ov2640_pixclk    pixel clock, all logic on the rising edge
//   reset            asynchronous, active-high
//   in_vsync         high during the active frame
//   in_href          high for valid pixels of a line
//   in_data          pixel value
//   threshold        binarisation threshold (sampled at frame start)
//   invert           invert binary result (sampled at frame start)
//   avg_en           0 = point sample, 1 = block average (sampled at frame start)
//   out_img          latched image, bit cy*IMG_W+cx, 1 = dark when not inverted
//   out_valid        one-cycle pulse when out_img updates
//   out_drop         one-cycle pulse when an incomplete frame is discarded
//   out_frame_count  accepted frame count, wraps 255 -> 0
module cam_bin_sampler #(
  parameter int DATA_WIDTH = 10,
  parameter int IMG_W      = 28,
  parameter int IMG_H      = 28,
  parameter int SHIFT_X    = 4,
  parameter int SHIFT_Y    = 4,
  parameter int OFFSET_X   = 0,
  parameter int OFFSET_Y   = 0,
  parameter int X_WIDTH    = 11,
  parameter int Y_WIDTH    = 10
) (
  input  logic                   ov2640_pixclk,
  input  logic                   reset,
  input  logic                   in_vsync,
  input  logic                   in_href,
  input  logic [DATA_WIDTH-1:0]  in_data,
  input  logic [DATA_WIDTH-1:0]  threshold,
  input  logic                   invert,
  input  logic                   avg_en,
  output logic [IMG_W*IMG_H-1:0] out_img,
  output logic                   out_valid,
  output logic                   out_drop,
  output logic [7:0]             out_frame_count
);

  localparam int NPIX   = IMG_W * IMG_H;
  localparam int ACC_W  = DATA_WIDTH + SHIFT_X + SHIFT_Y;
  localparam int CX_W   = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int IDX_W  = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int NEED_Y = OFFSET_Y + (IMG_H << SHIFT_Y);

  localparam logic [X_WIDTH-1:0] X_MASK = X_WIDTH'((1 << SHIFT_X) - 1);
  localparam logic [Y_WIDTH-1:0] Y_MASK = Y_WIDTH'((1 << SHIFT_Y) - 1);
  localparam logic [X_WIDTH-1:0] OFF_X  = X_WIDTH'(OFFSET_X);
  localparam logic [Y_WIDTH-1:0] OFF_Y  = Y_WIDTH'(OFFSET_Y);

  logic                  vsync_reg;
  logic                  line_reg;
  logic                  armed_reg;
  logic [X_WIDTH-1:0]    x_reg;
  logic [Y_WIDTH-1:0]    y_reg;
  logic [DATA_WIDTH-1:0] thr_reg;
  logic                  inv_reg;
  logic                  avg_reg;
  logic [NPIX-1:0]       work_reg;
  logic [ACC_W-1:0]      acc [IMG_W];

  logic                  frame_start;
  logic                  frame_end;
  logic                  line_end;
  logic [Y_WIDTH-1:0]    y_next;
  logic                  complete;
  logic                  pix_en;
  logic [X_WIDTH-1:0]    rx;
  logic [Y_WIDTH-1:0]    ry;
  logic [X_WIDTH-1:0]    cx_full;
  logic [Y_WIDTH-1:0]    cy_full;
  logic                  in_roi;
  logic [CX_W-1:0]       cx_idx;
  logic [IDX_W-1:0]      pix_idx;
  logic                  cell_first;
  logic                  cell_last;
  logic [ACC_W-1:0]      acc_base;
  logic [ACC_W-1:0]      sum;
  logic [ACC_W-1:0]      thr_scaled;
  logic                  write_en;
  logic                  wr_bit;

  always_comb begin
    frame_start = in_vsync & ~vsync_reg;
    frame_end   = ~in_vsync & vsync_reg & armed_reg;
    line_end    = line_reg & ~in_href;

    // y as it will be after this cycle; completeness uses it so that a line
    // whose href falls together with vsync still counts.
    y_next = y_reg;
    if (line_end && armed_reg && (y_reg != {Y_WIDTH{1'b1}})) begin
      y_next = y_reg + 1'b1;
    end
    complete = (int'(y_next) >= NEED_Y);

    pix_en  = in_vsync & armed_reg & in_href & ~frame_start;
    rx      = x_reg - OFF_X;
    ry      = y_reg - OFF_Y;
    cx_full = rx >> SHIFT_X;
    cy_full = ry >> SHIFT_Y;
    in_roi  = (x_reg >= OFF_X) && (y_reg >= OFF_Y) &&
              (int'(cx_full) < IMG_W) && (int'(cy_full) < IMG_H);
    cx_idx  = CX_W'(cx_full);
    pix_idx = IDX_W'(int'(cy_full) * IMG_W + int'(cx_full));

    cell_first = ((rx & X_MASK) == '0) && ((ry & Y_MASK) == '0);
    cell_last  = ((rx & X_MASK) == X_MASK) && ((ry & Y_MASK) == Y_MASK);

    // Starting the sum from zero on the first pixel also covers 1x1 cells,
    // where the first and last pixel coincide.
    acc_base   = cell_first ? '0 : acc[cx_idx];
    sum        = acc_base + ACC_W'(in_data);
    thr_scaled = ACC_W'(thr_reg) << (SHIFT_X + SHIFT_Y);

    write_en = pix_en & in_roi & (avg_reg ? cell_last : cell_first);
    wr_bit   = (avg_reg ? (sum < thr_scaled) : (in_data < thr_reg)) ^ inv_reg;
  end

  // Line accumulators hold no state across cells (each cell restarts from its
  // first pixel), so they need no reset.
  always_ff @(posedge ov2640_pixclk) begin
    if (pix_en && in_roi && avg_reg) begin
      acc[cx_idx] <= sum;
    end
  end

  always_ff @(posedge ov2640_pixclk or posedge reset) begin
    if (reset) begin
      // vsync_reg resets high so releasing reset in the middle of a frame is
      // not mistaken for a frame start.
      vsync_reg       <= 1'b1;
      line_reg        <= 1'b0;
      armed_reg       <= 1'b0;
      x_reg           <= '0;
      y_reg           <= '0;
      thr_reg         <= '0;
      inv_reg         <= 1'b0;
      avg_reg         <= 1'b0;
      work_reg        <= '0;
      out_img         <= '0;
      out_valid       <= 1'b0;
      out_drop        <= 1'b0;
      out_frame_count <= '0;
    end else begin
      vsync_reg <= in_vsync;
      line_reg  <= in_href & in_vsync & armed_reg;
      out_valid <= 1'b0;
      out_drop  <= 1'b0;

      if (!in_href) begin
        x_reg <= '0;
      end else if (x_reg != {X_WIDTH{1'b1}}) begin
        x_reg <= x_reg + 1'b1;
      end

      if (frame_start) begin
        armed_reg <= 1'b1;
        work_reg  <= '0;
        y_reg     <= '0;
        thr_reg   <= threshold;
        inv_reg   <= invert;
        avg_reg   <= avg_en;
      end else begin
        y_reg <= y_next;
        if (write_en) begin
          work_reg[pix_idx] <= wr_bit;
        end
        if (frame_end) begin
          armed_reg <= 1'b0;
          if (complete) begin
            out_img         <= work_reg;
            out_valid       <= 1'b1;
            out_frame_count <= out_frame_count + 8'd1;
          end else begin
            out_drop <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_cam_bin_sampler.sv
// tb_cam_bin_sampler
//   Directed bench for cam_bin_sampler using a reduced geometry: 4x4 cells of
//   4x4 pixels, ROI starting at (8,4). A full frame is 20 lines of 28 pixels.
module tb_cam_bin_sampler;

  localparam int DW = 10;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_vsync;
  logic          in_href;
  logic [DW-1:0] in_data;
  logic [DW-1:0] threshold;
  logic          invert;
  logic          avg_en;
  logic [15:0]   out_img;
  logic          out_valid;
  logic          out_drop;
  logic [7:0]    out_frame_count;

  int tests = 0;
  int fails = 0;

  cam_bin_sampler #(
    .DATA_WIDTH(DW), .IMG_W(4), .IMG_H(4), .SHIFT_X(2), .SHIFT_Y(2),
    .OFFSET_X(8), .OFFSET_Y(4), .X_WIDTH(11), .Y_WIDTH(10)
  ) dut (
    .ov2640_pixclk  (clk),
    .reset          (reset),
    .in_vsync       (in_vsync),
    .in_href        (in_href),
    .in_data        (in_data),
    .threshold      (threshold),
    .invert         (invert),
    .avg_en         (avg_en),
    .out_img        (out_img),
    .out_valid      (out_valid),
    .out_drop       (out_drop),
    .out_frame_count(out_frame_count)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pixel patterns. 1/2: cell (0,0) half 0 / half 1000 (or 800), rest 100.
  // 3: all 1000 except one dark pixel at (12,8).
  function automatic int pix(input int pat, input int x, input int y);
    bit blk;
    blk = (x >= 8) && (x < 12) && (y >= 4) && (y < 8);
    case (pat)
      1:       return blk ? ((((x - 8) + (y - 4) * 4) < 8) ? 0 : 1000) : 100;
      2:       return blk ? ((((x - 8) + (y - 4) * 4) < 8) ? 0 : 800) : 100;
      3:       return ((x == 12) && (y == 8)) ? 0 : 1000;
      default: return 100;
    endcase
  endfunction

  task automatic start_frame();
    in_vsync = 1'b0;
    in_href  = 1'b0;
    tick();
    tick();
    in_vsync = 1'b1;
    tick();
    tick();
  endtask

  // gap = 0 leaves href high so the caller can drop it together with vsync.
  task automatic send_line(input int width, input int y, input int pat, input int gap);
    for (int x = 0; x < width; x++) begin
      in_href = 1'b1;
      in_data = DW'(pix(pat, x, y));
      tick();
    end
    if (gap > 0) begin
      in_href = 1'b0;
      for (int g = 0; g < gap; g++) tick();
    end
  endtask

  task automatic end_frame(input string tag, input logic exp_valid, input logic exp_drop);
    in_href  = 1'b0;
    in_vsync = 1'b0;
    tick();
    check({tag, "_valid"}, 32'(out_valid), 32'(exp_valid));
    check({tag, "_drop"}, 32'(out_drop), 32'(exp_drop));
    tick();
    check({tag, "_pulse_end"}, 32'({out_valid, out_drop}), 32'd0);
  endtask

  // toggle_line >= 0: change invert and threshold mid-frame at that line.
  task automatic full_frame(input string tag, input int pat, input int nlines, input int width,
                            input int gap, input bit same_end, input int toggle_line,
                            input logic exp_valid, input logic exp_drop);
    start_frame();
    for (int y = 0; y < nlines; y++) begin
      if (y == toggle_line) begin
        invert    = ~invert;
        threshold = 10'd50;
      end
      send_line(width, y, pat, (same_end && (y == nlines - 1)) ? 0 : gap);
    end
    end_frame(tag, exp_valid, exp_drop);
  endtask

  initial begin
    reset     = 1'b1;
    in_vsync  = 1'b0;
    in_href   = 1'b0;
    in_data   = '0;
    threshold = 10'd450;
    invert    = 1'b0;
    avg_en    = 1'b0;
    tick();
    tick();
    check("rst_img", 32'(out_img), 32'h0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_drop", 32'(out_drop), 32'd0);
    check("rst_count", 32'(out_frame_count), 32'd0);
    reset = 1'b0;
    tick();

    // Point mode, all pixels 100 < 450 -> all dark.
    full_frame("pt_dark", 0, 20, 28, 3, 1'b0, -1, 1'b1, 1'b0);
    check("pt_dark_img", 32'(out_img), 32'hFFFF);
    check("pt_dark_cnt", 32'(out_frame_count), 32'd1);
    $display("[TB] frame pt_dark img=%h cnt=%0d", out_img, out_frame_count);

    invert = 1'b1;
    full_frame("pt_inv", 0, 20, 28, 3, 1'b0, -1, 1'b1, 1'b0);
    check("pt_inv_img", 32'(out_img), 32'h0000);
    check("pt_inv_cnt", 32'(out_frame_count), 32'd2);
    $display("[TB] frame pt_inv img=%h cnt=%0d", out_img, out_frame_count);

    // Invert/threshold change mid-frame must not affect this frame.
    invert = 1'b0;
    full_frame("pt_toggle", 0, 20, 28, 3, 1'b0, 5, 1'b1, 1'b0);
    check("pt_toggle_img", 32'(out_img), 32'hFFFF);
    check("pt_toggle_cnt", 32'(out_frame_count), 32'd3);
    $display("[TB] frame pt_toggle img=%h cnt=%0d", out_img, out_frame_count);
    invert    = 1'b0;
    threshold = 10'd450;

    // Average mode: cell 0 sum 8000 vs 7200 -> light; others mean 100 -> dark.
    avg_en = 1'b1;
    full_frame("avg500", 1, 20, 28, 3, 1'b0, -1, 1'b1, 1'b0);
    check("avg500_img", 32'(out_img), 32'hFFFE);
    check("avg500_cnt", 32'(out_frame_count), 32'd4);
    $display("[TB] frame avg500 img=%h cnt=%0d", out_img, out_frame_count);

    // Cell 0 sum 6400 < 7200 -> dark.
    full_frame("avg400", 2, 20, 28, 3, 1'b0, -1, 1'b1, 1'b0);
    check("avg400_img", 32'(out_img), 32'hFFFF);
    check("avg400_cnt", 32'(out_frame_count), 32'd5);
    $display("[TB] frame avg400 img=%h cnt=%0d", out_img, out_frame_count);

    // Point mode with ROI offset: dark pixel at (12,8) -> cell (1,1) -> bit 5.
    avg_en = 1'b0;
    full_frame("roi", 3, 20, 28, 3, 1'b0, -1, 1'b1, 1'b0);
    check("roi_img", 32'(out_img), 32'h0020);
    check("roi_cnt", 32'(out_frame_count), 32'd6);
    $display("[TB] frame roi img=%h cnt=%0d", out_img, out_frame_count);

    // Short frames are dropped and leave the image and count alone.
    full_frame("short15", 0, 15, 28, 3, 1'b0, -1, 1'b0, 1'b1);
    check("short15_img", 32'(out_img), 32'h0020);
    check("short15_cnt", 32'(out_frame_count), 32'd6);
    $display("[TB] frame short15 img=%h cnt=%0d", out_img, out_frame_count);

    full_frame("short19", 0, 19, 28, 3, 1'b0, -1, 1'b0, 1'b1);
    check("short19_img", 32'(out_img), 32'h0020);
    check("short19_cnt", 32'(out_frame_count), 32'd6);
    $display("[TB] frame short19 img=%h cnt=%0d", out_img, out_frame_count);

    // Last line's href falls on the same cycle as vsync: still complete.
    full_frame("same_end", 0, 20, 28, 3, 1'b1, -1, 1'b1, 1'b0);
    check("same_end_img", 32'(out_img), 32'hFFFF);
    check("same_end_cnt", 32'(out_frame_count), 32'd7);
    $display("[TB] frame same_end img=%h cnt=%0d", out_img, out_frame_count);

    // Reset in the middle of a frame: that frame produces nothing.
    start_frame();
    for (int y = 0; y < 5; y++) send_line(28, y, 0, 3);
    reset = 1'b1;
    tick();
    tick();
    check("midrst_img", 32'(out_img), 32'h0);
    check("midrst_cnt", 32'(out_frame_count), 32'd0);
    reset = 1'b0;
    for (int y = 5; y < 20; y++) send_line(28, y, 0, 3);
    end_frame("midrst", 1'b0, 1'b0);
    check("midrst_img_after", 32'(out_img), 32'h0);
    $display("[TB] frame midrst img=%h cnt=%0d", out_img, out_frame_count);

    full_frame("post_rst", 0, 20, 28, 3, 1'b0, -1, 1'b1, 1'b0);
    check("post_rst_img", 32'(out_img), 32'hFFFF);
    check("post_rst_cnt", 32'(out_frame_count), 32'd1);
    $display("[TB] frame post_rst img=%h cnt=%0d", out_img, out_frame_count);

    // Narrow frames (every pixel left of the ROI) to drive the counter to wrap.
    for (int f = 0; f < 254; f++) begin
      full_frame("wrap_fill", 0, 20, 1, 1, 1'b0, -1, 1'b1, 1'b0);
    end
    check("wrap_255", 32'(out_frame_count), 32'd255);
    check("wrap_img_cleared", 32'(out_img), 32'h0000);
    $display("[TB] frame wrap_255 img=%h cnt=%0d", out_img, out_frame_count);
    full_frame("wrap_last", 0, 20, 1, 1, 1'b0, -1, 1'b1, 1'b0);
    check("wrap_0", 32'(out_frame_count), 32'd0);
    $display("[TB] frame wrap_0 img=%h cnt=%0d", out_img, out_frame_count);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
